smi_rx_streamer: RTL
====================

SMI_RX_STREAMER -- requirements
Module: smi_rx_streamer

Interface
REQ-001 Parameter: DATA_W, default 32, FIFO word width; SHALL be a multiple of 8.
REQ-002 i_sys_clk  in  1  single system clock; all logic SHALL be synchronous to it.
REQ-003 i_rst_b  in  1  reset, SHALL be asynchronous, active-low.
REQ-004 i_enable  in  1  stream enable; low SHALL force IDLE at next edge.
REQ-005 i_fifo_empty  in  1  upstream RX complex FIFO empty flag.
REQ-006 o_fifo_pull  out  1  FIFO read enable; SHALL be a one-cycle pulse.
REQ-007 i_fifo_data  in  DATA_W  FIFO read data, valid one cycle after pull.
REQ-008 i_smi_soe_se  in  1  SMI read strobe, active-low, asynchronous to i_sys_clk.
REQ-009 o_smi_data  out  8  byte presented to SMI bus.
REQ-010 o_smi_data_oe  out  1  bus drive enable for the top-level tristate.
REQ-011 o_smi_irq  out  1  word-ready indication to host (SMI A0 line).

Function
REQ-012 i_smi_soe_se SHALL pass a 2-FF synchronizer; a strobe rising edge (end of read) SHALL be detected from the synchronized signal.
REQ-013 FSM states: IDLE, FETCH, LOAD, SEND.
REQ-014 IDLE->FETCH when i_enable=1 and i_fifo_empty=0; o_fifo_pull SHALL be 1 only during FETCH.
REQ-015 FETCH->LOAD unconditionally; LOAD SHALL capture i_fifo_data into the word register, clear byte index, and go to SEND.
REQ-016 In SEND, o_smi_data SHALL equal word byte [index], MSB first (index 0 = bits DATA_W-1..DATA_W-8); o_smi_irq SHALL be 1.
REQ-017 Each detected strobe end in SEND SHALL increment index; after the last byte (index DATA_W/8-1) next state SHALL be FETCH if FIFO non-empty, else IDLE.
REQ-018 Pull-to-first-byte latency SHALL be 2 cycles; strobe-end-to-next-byte latency SHALL be 3 cycles (2 sync + 1 edge register).
REQ-019 Strobe end outside SEND (underrun) SHALL be ignored by the FSM; o_smi_data SHALL be 8'h00 outside SEND.
REQ-020 o_smi_data_oe SHALL be 1 when i_enable=1 and synchronized strobe is low, else 0.
REQ-021 i_enable falling in any state SHALL abandon the held word and go IDLE; a pull already issued SHALL not be retried.
REQ-022 Strobe end coinciding with i_enable low SHALL have no effect besides going IDLE.

Reset
REQ-023 On i_rst_b=0: state IDLE, index 0, word 0, sync flops 1 (strobe inactive), o_fifo_pull 0, o_smi_data 8'h00, o_smi_data_oe 0, o_smi_irq 0.
REQ-024 Reset assertion mid-word SHALL discard the word immediately; deassertion SHALL resume from IDLE.

Configuration
REQ-025 Macro SMI_RX_UNDERRUN_CNT_EN defined: add output o_underrun_cnt (8 bits), counting strobe ends outside SEND while enabled, saturating at 8'hFF, cleared by reset or i_enable low.
REQ-026 Macro undefined: port and counter SHALL be absent; behaviour otherwise identical.

Structure
REQ-027 State encoding and SMI byte width constant SHALL live in a shared package used by smi_ctrl.
REQ-028 The strobe synchronizer and edge detector SHALL be sub-module smi_strobe_sync.

Verification
REQ-029 FIFO holds 32'hA1B2C3D4, enable=1, 4 strobes -> bytes A1,B2,C3,D4, one pull, irq drops, IDLE.
REQ-030 Two words queued, 8 strobes -> 8 bytes in order, exactly two pulls, irq high between words except FETCH/LOAD cycles.
REQ-031 Empty FIFO, 3 strobes -> o_smi_data 8'h00, no pull, underrun count 3 (with macro).
REQ-032 i_enable dropped after 2 bytes of 32'h11223344 -> IDLE next cycle, irq 0; re-enable with next word 32'h55667788 -> byte 55 first.
REQ-033 i_rst_b asserted mid-SEND -> all outputs at reset values asynchronously; after release, no spurious pull when FIFO empty.
REQ-034 Strobe pulses 2 cycles wide -> each counted exactly once, no missed/duplicate bytes.

Source files
------------

// File: rtl/smi_rx_streamer_pkg.sv
// Shared definitions for the SMI RX streamer: controller state encoding and SMI byte width.
package smi_rx_streamer_pkg;

  localparam int SMI_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND
  } state_t;

endpackage

// File: rtl/smi_rx_streamer_if.sv
// FIFO read port and SMI byte bus of the RX streamer.
// The master side belongs to the streamer; the slave side belongs to the FIFO/SMI environment.
interface smi_rx_streamer_if #(
  parameter int DATA_W = 32
);
  import smi_rx_streamer_pkg::*;

  logic                  i_fifo_empty;
  logic                  o_fifo_pull;
  logic [DATA_W-1:0]     i_fifo_data;
  logic                  i_smi_soe_se;
  logic [SMI_BYTE_W-1:0] o_smi_data;
  logic                  o_smi_data_oe;
  logic                  o_smi_irq;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_smi_soe_se,
    output o_fifo_pull,
    output o_smi_data,
    output o_smi_data_oe,
    output o_smi_irq
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    output i_smi_soe_se,
    input  o_fifo_pull,
    input  o_smi_data,
    input  o_smi_data_oe,
    input  o_smi_irq
  );

endinterface

// File: rtl/smi_strobe_sync.sv
// Two-flop synchronizer for the asynchronous SMI read strobe plus rising-edge (end of read) detect.
// strobe_end is combinational from the edge register so the controller reacts on the following edge.
module smi_strobe_sync (
  input  logic i_sys_clk,
  input  logic i_rst_b,
  input  logic strobe_async,
  output logic strobe_sync,
  output logic strobe_end
);

  logic [1:0] sync_q;
  logic       edge_q;

  // Flops reset high: the strobe is active-low, so high means "no read in progress".
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sync_q <= 2'b11;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], strobe_async};
      edge_q <= sync_q[1];
    end
  end

  assign strobe_sync = sync_q[1];
  assign strobe_end  = sync_q[1] & ~edge_q;

endmodule

// File: rtl/smi_rx_streamer.sv
// Streams FIFO words to the SMI bus one byte per host read strobe, MSB byte first.
// Optional feature: define SMI_RX_UNDERRUN_CNT_EN to add the o_underrun_cnt saturating counter.
module smi_rx_streamer
  import smi_rx_streamer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                      i_sys_clk,
  input  logic                      i_rst_b,
  input  logic                      i_enable,
  smi_rx_streamer_if.master         bus
`ifdef SMI_RX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                o_underrun_cnt
`endif
);

  localparam int NBYTES = DATA_W / SMI_BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state;
  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              strobe_sync;
  logic              strobe_end;

  function automatic logic [SMI_BYTE_W-1:0] word_byte(input logic [DATA_W-1:0] w,
                                                       input logic [IDX_W-1:0]  i);
    return w[DATA_W - 1 - SMI_BYTE_W * int'(i) -: SMI_BYTE_W];
  endfunction

  smi_strobe_sync u_strobe_sync (
    .i_sys_clk    (i_sys_clk),
    .i_rst_b      (i_rst_b),
    .strobe_async (bus.i_smi_soe_se),
    .strobe_sync  (strobe_sync),
    .strobe_end   (strobe_end)
  );

  // Drive the bus only while the host holds the read strobe low.
  assign bus.o_smi_data_oe = i_enable & ~strobe_sync;

  // NOTE: state uses <= so every flop samples pre-edge values whatever the statement order.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state           <= ST_IDLE;
      // NOTE: the word register is reset because a discarded word must never reappear; plain data storage would normally stay unreset.
      word_q          <= '0;
      idx_q           <= '0;
      bus.o_fifo_pull <= 1'b0;
      bus.o_smi_data  <= '0;
      bus.o_smi_irq   <= 1'b0;
    end else if (!i_enable) begin
      // Abandon everything; a pull already on the bus is not reissued.
      state           <= ST_IDLE;
      word_q          <= '0;
      idx_q           <= '0;
      bus.o_fifo_pull <= 1'b0;
      bus.o_smi_data  <= '0;
      bus.o_smi_irq   <= 1'b0;
    end else begin
      bus.o_fifo_pull <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.i_fifo_empty) begin
            state           <= ST_FETCH;
            bus.o_fifo_pull <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          word_q         <= bus.i_fifo_data;
          idx_q          <= '0;
          bus.o_smi_data <= bus.i_fifo_data[DATA_W-1 -: SMI_BYTE_W];
          bus.o_smi_irq  <= 1'b1;
          state          <= ST_SEND;
        end
        ST_SEND: begin
          if (strobe_end) begin
            if (idx_q == LAST_IDX) begin
              idx_q          <= '0;
              bus.o_smi_data <= '0;
              bus.o_smi_irq  <= 1'b0;
              if (!bus.i_fifo_empty) begin
                state           <= ST_FETCH;
                bus.o_fifo_pull <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx_q          <= idx_q + 1'b1;
              bus.o_smi_data <= word_byte(word_q, idx_q + 1'b1);
            end
          end
        end
        // NOTE: a default arm keeps the case total; the same gap in combinational code would infer a latch.
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SMI_RX_UNDERRUN_CNT_EN
  logic [7:0] underrun_q;

  // Host reads that arrive while no byte is presented, saturating.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      underrun_q <= '0;
    end else if (!i_enable) begin
      underrun_q <= '0;
    end else if (strobe_end && (state != ST_SEND) && (underrun_q != 8'hFF)) begin
      underrun_q <= underrun_q + 8'd1;
    end
  end

  assign o_underrun_cnt = underrun_q;
`endif

endmodule
